// File: rtl/ex_weight_bank_stream.sv
// rtl/ex_weight_bank_stream.sv - weight row bank with a beat-wise row loader and a burst row reader
module ex_weight_bank_stream #(
  parameter int DATA_WIDTH = 14,
  parameter int LANES      = 256,
  parameter int DEPTH      = 657,
  parameter int ADDR_W     = 10,
  parameter int BEAT       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         err_clr,
  input  logic                         ld_start,
  input  logic [ADDR_W-1:0]            ld_base,
  input  logic [ADDR_W-1:0]            ld_rows,
  input  logic                         ld_valid,
  input  logic [BEAT*DATA_WIDTH-1:0]   ld_data,
  output logic                         ld_ready,
  output logic                         ld_done,
  input  logic                         rd_start,
  input  logic [ADDR_W-1:0]            rd_base,
  input  logic [ADDR_W-1:0]            rd_count,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [LANES*DATA_WIDTH-1:0]  rd_data,
  output logic                         rd_busy,
  output logic                         err
);
  localparam int NBEATS = LANES / BEAT;
  localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int ROW_W  = LANES * DATA_WIDTH;
  localparam int BEAT_W = BEAT * DATA_WIDTH;
  localparam logic [ADDR_W:0]  DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [BCW-1:0]   LAST_BEAT = BCW'(NBEATS - 1);

  typedef enum logic {L_IDLE, L_FILL}   ld_state_e;
  typedef enum logic {R_IDLE, R_STREAM} rd_state_e;

  ld_state_e          ld_state_q, ld_state_d;
  logic [ADDR_W-1:0]  row_ptr_q, row_ptr_d;
  logic [ADDR_W-1:0]  rows_left_q, rows_left_d;
  logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
  logic               ld_done_q, ld_done_d;
  logic [ROW_W-1:0]   stage_q, row_wdata;
  logic               beat_acc, row_commit, ld_bad, ld_err_evt;

  rd_state_e          rd_state_q, rd_state_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]  rd_left_q, rd_left_d;
  logic               rd_valid_q, rd_valid_d;
  logic [ROW_W-1:0]   rd_data_q;
  logic               rd_issue, rd_bad, rd_err_evt;

  logic               err_q, err_d;

  logic [ROW_W-1:0]   mem [DEPTH];

  assign ld_bad = (ld_rows == '0) || (({1'b0, ld_base} + {1'b0, ld_rows}) > DEPTH_C);
  assign rd_bad = (rd_count == '0) || (({1'b0, rd_base} + {1'b0, rd_count}) > DEPTH_C);

  // The incoming beat is merged into the staging image so the last beat can commit the full row directly.
  always_comb begin
    ld_state_d  = ld_state_q;
    row_ptr_d   = row_ptr_q;
    rows_left_d = rows_left_q;
    beat_cnt_d  = beat_cnt_q;
    ld_done_d   = 1'b0;
    ld_err_evt  = 1'b0;
    beat_acc    = 1'b0;
    row_commit  = 1'b0;
    row_wdata   = stage_q;
    row_wdata[int'(beat_cnt_q)*BEAT_W +: BEAT_W] = ld_data;
    case (ld_state_q)
      L_IDLE: begin
        if (en && ld_start) begin
          if (ld_bad) begin
            ld_err_evt = 1'b1;
          end else begin
            row_ptr_d   = ld_base;
            rows_left_d = ld_rows;
            beat_cnt_d  = '0;
            ld_state_d  = L_FILL;
          end
        end
      end
      L_FILL: begin
        if (en && ld_valid) begin
          beat_acc = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            row_commit  = 1'b1;
            beat_cnt_d  = '0;
            row_ptr_d   = row_ptr_q + ADDR_W'(1);
            rows_left_d = rows_left_q - ADDR_W'(1);
            if (rows_left_q == ADDR_W'(1)) begin
              ld_state_d = L_IDLE;
              ld_done_d  = 1'b1;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end
      end
      default: ld_state_d = L_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_left_d  = rd_left_q;
    rd_valid_d = rd_valid_q;
    rd_issue   = 1'b0;
    rd_err_evt = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (en && rd_start) begin
          if (rd_bad) begin
            rd_err_evt = 1'b1;
          end else begin
            rd_ptr_d   = rd_base;
            rd_left_d  = rd_count;
            rd_state_d = R_STREAM;
          end
        end
      end
      R_STREAM: begin
        if (en) begin
          if ((!rd_valid_q || rd_ready) && (rd_left_q != '0)) begin
            rd_issue   = 1'b1;
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            rd_left_d  = rd_left_q - ADDR_W'(1);
          end else if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
            rd_state_d = R_IDLE;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // An error event in the same cycle as err_clr keeps err set.
  assign err_d = (ld_err_evt || rd_err_evt) ? 1'b1 : (err_clr ? 1'b0 : err_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state_q  <= L_IDLE;
      row_ptr_q   <= '0;
      rows_left_q <= '0;
      beat_cnt_q  <= '0;
      ld_done_q   <= 1'b0;
      rd_state_q  <= R_IDLE;
      rd_ptr_q    <= '0;
      rd_left_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      ld_state_q  <= ld_state_d;
      row_ptr_q   <= row_ptr_d;
      rows_left_q <= rows_left_d;
      beat_cnt_q  <= beat_cnt_d;
      ld_done_q   <= ld_done_d;
      rd_state_q  <= rd_state_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_left_q   <= rd_left_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
      if (rd_issue) begin
        rd_data_q <= mem[rd_ptr_q];
      end
    end
  end

  // Storage is not reset; a reset mid-load leaves the staging image stale, which the next load overwrites.
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      stage_q <= row_wdata;
    end
    if (row_commit) begin
      mem[row_ptr_q] <= row_wdata;
    end
  end

  assign ld_ready = (ld_state_q == L_FILL);
  assign ld_done  = ld_done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_busy  = (rd_state_q != R_IDLE);
  assign err      = err_q;

endmodule

// File: doc/ex_weight_bank_stream.md
EX_WEIGHT_BANK_STREAM -- requirements
Module: ex_weight_bank_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14: bits per weight lane.
REQ-002 SHALL have parameter LANES, default 256: weights per memory row.
REQ-003 SHALL have parameter DEPTH, default 657: rows stored.
REQ-004 SHALL have parameter ADDR_W, default 10: row index width; ceil(log2(DEPTH)) <= ADDR_W.
REQ-005 SHALL have parameter BEAT, default 16: lanes per load beat; LANES % BEAT == 0; NBEATS = LANES/BEAT.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port en, input, 1: global advance enable.
REQ-009 SHALL have port err_clr, input, 1: clears err.
REQ-010 SHALL have port ld_start, input, 1: begin row load.
REQ-011 SHALL have port ld_base, input, ADDR_W: first row to write.
REQ-012 SHALL have port ld_rows, input, ADDR_W: rows to write.
REQ-013 SHALL have port ld_valid, input, 1: ld_data beat valid.
REQ-014 SHALL have port ld_data, input, BEAT*DATA_WIDTH: signed lanes; lane 0 in LSBs.
REQ-015 SHALL have port ld_ready, output, 1: beat accepted when ld_valid&&ld_ready&&en.
REQ-016 SHALL have port ld_done, output, 1: one-cycle pulse at load completion.
REQ-017 SHALL have port rd_start, input, 1: begin burst read.
REQ-018 SHALL have port rd_base, input, ADDR_W: first row to read.
REQ-019 SHALL have port rd_count, input, ADDR_W: rows to read.
REQ-020 SHALL have port rd_ready, input, 1: consumer accepts rd_data.
REQ-021 SHALL have port rd_valid, output, 1: rd_data valid.
REQ-022 SHALL have port rd_data, output, LANES*DATA_WIDTH: signed row; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-023 SHALL have port rd_busy, output, 1: read FSM not in R_IDLE.
REQ-024 SHALL have port err, output, 1: sticky range/parameter error.

Function
REQ-025 Load FSM SHALL have states L_IDLE and L_FILL; ld_ready=1 only in L_FILL.
REQ-026 In L_IDLE, ld_start&&en SHALL latch row_ptr=ld_base, rows_left=ld_rows and beat_cnt=0, then enter L_FILL; ld_rows==0 or ld_base+ld_rows>DEPTH SHALL instead set err and stay in L_IDLE.
REQ-027 Each accepted beat SHALL store ld_data into staging lanes [beat_cnt*BEAT +: BEAT] and increment beat_cnt.
REQ-028 On the beat with beat_cnt==NBEATS-1, the full row (staging plus current beat) SHALL be written to row_ptr that clock edge, with beat_cnt->0, row_ptr+1 and rows_left-1.
REQ-029 When rows_left reaches 0, the FSM SHALL return to L_IDLE and assert ld_done for exactly the following cycle.
REQ-030 ld_start in L_FILL SHALL be ignored.
REQ-031 Read FSM SHALL have states R_IDLE and R_STREAM; rd_start&&en in R_IDLE latches rd_ptr=rd_base and rd_left=rd_count; count 0 or overflow sets err and stays in R_IDLE.
REQ-032 Memory read SHALL be synchronous: row at rd_ptr appears on rd_data with rd_valid=1 one cycle after issue; first issue is the cycle after rd_start.
REQ-033 A new read SHALL issue only when en && (!rd_valid || rd_ready) && rd_left>0, giving one row per cycle under continuous rd_ready.
REQ-034 With rd_valid=1 and rd_ready=0, rd_data and rd_valid SHALL hold unchanged.
REQ-035 After the last row is accepted, rd_valid SHALL drop and the FSM SHALL return to R_IDLE; rd_start in R_STREAM SHALL be ignored.
REQ-036 A read issued in the same cycle a row commit targets the same row SHALL return the old contents (read-before-write).
REQ-037 With en=0, neither FSM, counter nor memory row SHALL change; ld_ready stays at its state-defined value, but no beat is accepted.
REQ-038 err SHALL be cleared by err_clr unless an error event occurs in the same cycle, in which case set wins.

Reset
REQ-039 rst low SHALL asynchronously force both FSMs to idle, all counters to 0, and ld_ready, ld_done, rd_valid, rd_busy, err and rd_data to 0.
REQ-040 Memory array contents SHALL NOT be cleared by reset.
REQ-041 Reset mid-load SHALL discard the partially staged row; rows already committed SHALL remain.

Verification
REQ-042 Load ld_base=5, ld_rows=2, BEAT=16 with lane value = lane index + row*256 -> ld_ready high for 32 beats; ld_done pulses once; rd_base=5, rd_count=2 returns both rows bit-exact.
REQ-043 Burst read of 4 rows with rd_ready=1 -> rd_valid high 4 consecutive cycles starting 2 cycles after rd_start; then rd_busy=0.
REQ-044 Drop rd_ready for 3 cycles mid-burst -> rd_data frozen; no row skipped or duplicated.
REQ-045 ld_base=650, ld_rows=10 (DEPTH=657) -> err=1, no memory write; err_clr -> err=0.
REQ-046 Commit row 7 while a read of row 7 issues in the same cycle -> old row 7 returned; the next read of row 7 returns new data.
REQ-047 Assert rst during beat 10 of a load -> all outputs 0 immediately; previously committed rows still read back correctly.
